// File: rtl/top_intr_pkg.sv
// Shared types and constants for the interrupt demonstration core.
package top_intr_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_t;

    localparam int          NUM_SRC         = 2;
    localparam logic [1:0]  CAUSE_T0        = 2'd0;
    localparam logic [1:0]  CAUSE_T1        = 2'd1;
    localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0180;

endpackage

// File: rtl/intr_timer.sv
// Free-running interval timer. The tick is high during the cycle whose
// closing edge wraps the counter, so the consumer registers the event on that edge.
module intr_timer #(
    parameter int PERIOD = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/top_intr.sv
// Interrupt lab top: two timers, sticky pending bits, fixed-priority
// arbitration and a PC-stub sequencer that vectors, runs a fixed ISR and returns.
module top_intr
    import top_intr_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [PC_W-1:0] VECTOR_BASE = PC_W'(VECTOR_BASE_DEF),
    parameter int              T0_PERIOD   = 16,
    parameter int              T1_PERIOD   = 40,
    parameter int              ISR_LEN     = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    epc,
    output logic [1:0]         cause,
    output logic               in_isr,
    output logic               irq_ack,
    output logic [NUM_SRC-1:0] pending,
    output logic               ie
);

    localparam int IW = (ISR_LEN > 2) ? $clog2(ISR_LEN) : 1;

    state_t               state;
    logic [IW-1:0]        isr_cnt;
    logic [NUM_SRC-1:0]   tick;
    logic [NUM_SRC-1:0]   clr;
    logic [NUM_SRC-1:0]   pend_nxt;
    logic                 take;
    logic                 id;
    logic [PC_W-1:0]      vector;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_tmr
        localparam int P = (g == 0) ? T0_PERIOD : T1_PERIOD;
        intr_timer #(.PERIOD(P)) u_tmr (
            .clk   (clk),
            .reset (reset),
            .tick  (tick[g])
        );
    end

    // Timer0 wins: pick bit 0 whenever it is set.
    always_comb begin
        take   = (state == ST_RUN) && ie && (pending != '0);
        id     = ~pending[0];
        vector = VECTOR_BASE + (PC_W'(id) << 3);
        clr    = '0;
        if (take) clr[id] = 1'b1;
        // A tick landing on the clearing edge keeps the bit set.
        pend_nxt = (pending & ~clr) | tick;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            epc     <= '0;
            cause   <= CAUSE_T0;
            in_isr  <= 1'b0;
            irq_ack <= 1'b0;
            pending <= '0;
            ie      <= 1'b1;
            isr_cnt <= '0;
        end else begin
            pending <= pend_nxt;
            irq_ack <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (take) begin
                        epc     <= pc;
                        pc      <= vector;
                        cause   <= {1'b0, id};
                        ie      <= 1'b0;
                        in_isr  <= 1'b1;
                        isr_cnt <= '0;
                        irq_ack <= 1'b1;
                        state   <= ST_ISR;
                    end else begin
                        pc <= pc + PC_W'(4);
                    end
                end
                ST_ISR: begin
                    if (isr_cnt == IW'(ISR_LEN - 1)) begin
                        pc     <= epc;
                        ie     <= 1'b1;
                        in_isr <= 1'b0;
                        state  <= ST_RUN;
                    end else begin
                        pc      <= pc + PC_W'(4);
                        isr_cnt <= isr_cnt + IW'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_top_intr.sv
// Bench for top_intr: three instances (default, equal periods, short timer0 with long ISR)
// checked against per-edge expectations queued ahead of each clock edge.
module tb_top_intr;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        in_isr;
        logic        irq_ack;
        logic [1:0]  pending;
        logic        ie;
    } obs_t;

    typedef struct {
        int   dut;
        int   edge_no;
        obs_t o;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_w   [3];
    logic [31:0] epc_w  [3];
    logic [1:0]  cause_w[3];
    logic        isr_w  [3];
    logic        ack_w  [3];
    logic [1:0]  pend_w [3];
    logic        ie_w   [3];

    exp_t sb[$];
    int   edge_no;
    int   checks;
    int   errors;

    top_intr dut0 (
        .clk(clk), .reset(reset), .pc(pc_w[0]), .epc(epc_w[0]), .cause(cause_w[0]),
        .in_isr(isr_w[0]), .irq_ack(ack_w[0]), .pending(pend_w[0]), .ie(ie_w[0])
    );

    top_intr #(.T0_PERIOD(8), .T1_PERIOD(8)) dut1 (
        .clk(clk), .reset(reset), .pc(pc_w[1]), .epc(epc_w[1]), .cause(cause_w[1]),
        .in_isr(isr_w[1]), .irq_ack(ack_w[1]), .pending(pend_w[1]), .ie(ie_w[1])
    );

    top_intr #(.T0_PERIOD(5), .ISR_LEN(6)) dut2 (
        .clk(clk), .reset(reset), .pc(pc_w[2]), .epc(epc_w[2]), .cause(cause_w[2]),
        .in_isr(isr_w[2]), .irq_ack(ack_w[2]), .pending(pend_w[2]), .ie(ie_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [31:0] pc, input logic [31:0] epc,
                                input logic [1:0] cause, input logic in_isr,
                                input logic ack, input logic [1:0] pend, input logic ie);
        obs_t o;
        o.pc = pc; o.epc = epc; o.cause = cause; o.in_isr = in_isr;
        o.irq_ack = ack; o.pending = pend; o.ie = ie;
        return o;
    endfunction

    function automatic obs_t get_obs(input int d);
        return mk(pc_w[d], epc_w[d], cause_w[d], isr_w[d], ack_w[d], pend_w[d], ie_w[d]);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h epc=%h cause=%0d in_isr=%b ack=%b pend=%b ie=%b",
                         o.pc, o.epc, o.cause, o.in_isr, o.irq_ack, o.pending, o.ie);
    endfunction

    function automatic void push(input int d, input int e, input obs_t o);
        exp_t x;
        x.dut = d; x.edge_no = e; x.o = o;
        sb.push_back(x);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        edge_no = 0;
        #1;
    endtask

    task automatic test_reset();
        obs_t rv;
        reset = 1'b0;
        apply_reset();
        rv = mk(32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== rv) begin
                errors++;
                $display("FAIL reset dut%0d got %s want %s", d, fmt(get_obs(d)), fmt(rv));
            end
        end
    endtask

    task automatic test_run_count();
        exp_t e;
        obs_t a;
        for (int k = 1; k <= 16; k++)
            push(0, k, mk(32'(4 * k), 32'h0, 2'd0, 1'b0, 1'b0, (k == 16) ? 2'b01 : 2'b00, 1'b1));
        for (int k = 1; k <= 16; k++) begin
            step();
            while (sb.size() > 0 && sb[0].edge_no == edge_no) begin
                e = sb.pop_front();
                a = get_obs(e.dut);
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL run_count edge=%0d got %s want %s", edge_no, fmt(a), fmt(e.o));
                end
            end
        end
    endtask

    task automatic test_first_entry();
        exp_t e;
        obs_t a;
        push(0, 17, mk(32'h180, 32'd64, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0));
        push(0, 18, mk(32'h184, 32'd64, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0));
        push(0, 19, mk(32'h188, 32'd64, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0));
        push(0, 20, mk(32'h18C, 32'd64, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0));
        push(0, 21, mk(32'd64,  32'd64, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1));
        push(0, 22, mk(32'd68,  32'd64, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1));
        for (int k = 17; k <= 22; k++) begin
            step();
            while (sb.size() > 0 && sb[0].edge_no == edge_no) begin
                e = sb.pop_front();
                a = get_obs(e.dut);
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL entry_return edge=%0d got %s want %s", edge_no, fmt(a), fmt(e.o));
                end
            end
        end
    endtask

    task automatic test_reset_mid_isr();
        exp_t e;
        obs_t a;
        obs_t rv;
        rv = mk(32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        apply_reset();
        push(0, 19, mk(32'h188, 32'd64, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0));
        for (int k = 1; k <= 19; k++) begin
            step();
            while (sb.size() > 0 && sb[0].edge_no == edge_no) begin
                e = sb.pop_front();
                a = get_obs(e.dut);
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL pre_abort edge=%0d got %s want %s", edge_no, fmt(a), fmt(e.o));
                end
            end
        end
        // Mid-cycle, well away from any clock edge.
        #2 reset = 1'b0;
        #1;
        a = get_obs(0);
        checks++;
        if (a !== rv) begin
            errors++;
            $display("FAIL async_abort got %s want %s", fmt(a), fmt(rv));
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        edge_no = 0;
        step();
        a = get_obs(0);
        checks++;
        if (a !== mk(32'd4, 32'h0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1)) begin
            errors++;
            $display("FAIL restart got %s want pc=4 rest reset values", fmt(a));
        end
    endtask

    task automatic test_priority();
        exp_t e;
        obs_t a;
        apply_reset();
        push(1, 8,  mk(32'd32,  32'h0,  2'd0, 1'b0, 1'b0, 2'b11, 1'b1));
        push(1, 9,  mk(32'h180, 32'd32, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0));
        push(1, 13, mk(32'd32,  32'd32, 2'd0, 1'b0, 1'b0, 2'b10, 1'b1));
        push(1, 14, mk(32'h188, 32'd32, 2'd1, 1'b1, 1'b1, 2'b00, 1'b0));
        push(1, 16, mk(32'h190, 32'd32, 2'd1, 1'b1, 1'b0, 2'b11, 1'b0));
        for (int k = 1; k <= 16; k++) begin
            step();
            while (sb.size() > 0 && sb[0].edge_no == edge_no) begin
                e = sb.pop_front();
                a = get_obs(e.dut);
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL priority edge=%0d got %s want %s", edge_no, fmt(a), fmt(e.o));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t a;
        apply_reset();
        push(2, 5,  mk(32'd20,  32'h0,  2'd0, 1'b0, 1'b0, 2'b01, 1'b1));
        push(2, 6,  mk(32'h180, 32'd20, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0));
        push(2, 10, mk(32'h190, 32'd20, 2'd0, 1'b1, 1'b0, 2'b01, 1'b0));
        push(2, 12, mk(32'd20,  32'd20, 2'd0, 1'b0, 1'b0, 2'b01, 1'b1));
        push(2, 13, mk(32'h180, 32'd20, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0));
        push(2, 19, mk(32'd20,  32'd20, 2'd0, 1'b0, 1'b0, 2'b01, 1'b1));
        // Entry clears bit 0 on the same edge timer0 fires again.
        push(2, 20, mk(32'h180, 32'd20, 2'd0, 1'b1, 1'b1, 2'b01, 1'b0));
        for (int k = 1; k <= 20; k++) begin
            step();
            while (sb.size() > 0 && sb[0].edge_no == edge_no) begin
                e = sb.pop_front();
                a = get_obs(e.dut);
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL back_to_back edge=%0d got %s want %s", edge_no, fmt(a), fmt(e.o));
                end
            end
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        edge_no = 0;
        reset   = 1'b0;
        test_reset();
        test_run_count();
        test_first_entry();
        test_reset_mid_isr();
        test_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
